// File: rtl/speech_write_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : speech_write_fifo_if
//  Description : CPC write strobes and data, ATmega byte handshake, and
//                status signals for the speech write FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
interface speech_write_fifo_if;
  logic       iWRITE_SSA;
  logic       iWRITE_DK;
  logic [7:0] iCPC_DATA;
  logic       iACK;
  logic       iCLR_OVF;
  logic [7:0] oBYTE;
  logic       oBYTE_DK;
  logic       oVALID;
  logic       oEMPTY;
  logic       oFULL;
  logic       oOVERFLOW;
  logic [7:0] oSTATUS;

  // FIFO side: takes strobes, data and ack, drives byte and status
  modport slave (
    input  iWRITE_SSA, iWRITE_DK, iCPC_DATA, iACK, iCLR_OVF,
    output oBYTE, oBYTE_DK, oVALID, oEMPTY, oFULL, oOVERFLOW, oSTATUS
  );

  // Environment side: CPC decoder plus ATmega
  modport master (
    output iWRITE_SSA, iWRITE_DK, iCPC_DATA, iACK, iCLR_OVF,
    input  oBYTE, oBYTE_DK, oVALID, oEMPTY, oFULL, oOVERFLOW, oSTATUS
  );
endinterface
`default_nettype wire

// File: rtl/speech_write_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : speech_write_fifo
//  Description : Synchronises the asynchronous CPC speech write strobes,
//                queues {port tag, byte} in a small FIFO and hands each
//                entry to the ATmega over a four-phase valid/ack handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module speech_write_fifo #(
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                iCLK,
  input  logic                iRESET,
  speech_write_fifo_if.slave  bus
);
  localparam int         PTR_W   = $clog2(DEPTH);
  localparam logic [3:0] C_DEPTH = 4'(DEPTH);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESENT  = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] r_wr_sync;
  logic [SYNC_STAGES-1:0] r_dk_sync;
  logic [SYNC_STAGES-1:0] r_ack_sync;
  logic                   r_wr_hist;
  logic                   r_ack_hist;

  logic [8:0]             r_mem [DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [3:0]             r_level;
  logic                   r_empty;
  logic                   r_full;
  logic                   r_ovf;

  state_t                 r_state;
  logic [7:0]             r_byte;
  logic                   r_byte_dk;
  logic                   r_valid;

  logic                   w_strobe;
  logic                   w_push;
  logic                   w_tag;
  logic                   w_ack_s;
  logic                   w_ack_rise;
  logic                   w_pop;
  logic                   w_accept;
  logic                   w_drop;
  logic [3:0]             w_level_nxt;

  assign w_strobe   = bus.iWRITE_SSA | bus.iWRITE_DK;
  assign w_push     = r_wr_sync[SYNC_STAGES-1] & ~r_wr_hist;
  // DK strobe travels alongside the combined strobe, so a simultaneous
  // SSA+DK write is tagged as DK.
  assign w_tag      = r_dk_sync[SYNC_STAGES-1];
  assign w_ack_s    = r_ack_sync[SYNC_STAGES-1];
  assign w_ack_rise = w_ack_s & ~r_ack_hist;
  // A head entry is always present in PRESENT, so a pop never underflows.
  assign w_pop      = (r_state == PRESENT) & w_ack_rise;

  // Push/pop arbitration: a pop frees the slot a same-cycle push needs
  always_comb begin
    w_accept    = w_push & (~r_full | w_pop);
    w_drop      = w_push & r_full & ~w_pop;
    w_level_nxt = r_level;
    if (w_accept && !w_pop) begin
      w_level_nxt = r_level + 4'd1;
    end else if (w_pop && !w_accept) begin
      w_level_nxt = r_level - 4'd1;
    end
  end

  // Input synchronisers with one history flop for edge detection
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      r_wr_sync  <= '0;
      r_dk_sync  <= '0;
      r_ack_sync <= '0;
      r_wr_hist  <= 1'b0;
      r_ack_hist <= 1'b0;
    end else begin
      r_wr_sync  <= {r_wr_sync[SYNC_STAGES-2:0], w_strobe};
      r_dk_sync  <= {r_dk_sync[SYNC_STAGES-2:0], bus.iWRITE_DK};
      r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], bus.iACK};
      r_wr_hist  <= r_wr_sync[SYNC_STAGES-1];
      r_ack_hist <= w_ack_s;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge iCLK) begin
    if (w_accept) begin
      r_mem[r_wr_ptr] <= {w_tag, bus.iCPC_DATA};
    end
  end

  // Pointers, level, flags and sticky overflow
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= 4'd0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_level <= w_level_nxt;
      r_empty <= (w_level_nxt == 4'd0);
      r_full  <= (w_level_nxt == C_DEPTH);
      // Set has priority over a same-cycle clear
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (bus.iCLR_OVF) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // Four-phase handshake FSM with registered byte, tag and valid
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      r_state   <= IDLE;
      r_valid   <= 1'b0;
      r_byte    <= 8'h00;
      r_byte_dk <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // Waiting for ack low keeps a stale high ack from popping
          if (!r_empty && !w_ack_s) begin
            {r_byte_dk, r_byte} <= r_mem[r_rd_ptr];
            r_valid             <= 1'b1;
            r_state             <= PRESENT;
          end
        end
        PRESENT: begin
          if (w_ack_rise) begin
            r_valid <= 1'b0;
            r_state <= WAIT_LOW;
          end
        end
        WAIT_LOW: begin
          if (!w_ack_s) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.oBYTE     = r_byte;
  assign bus.oBYTE_DK  = r_byte_dk;
  assign bus.oVALID    = r_valid;
  assign bus.oEMPTY    = r_empty;
  assign bus.oFULL     = r_full;
  assign bus.oOVERFLOW = r_ovf;
  assign bus.oSTATUS   = {r_ovf, r_full, r_empty, 1'b0, r_level};
endmodule
`default_nettype wire

// File: tb/tb_speech_write_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_speech_write_fifo
//  Description : Directed self-checking bench for speech_write_fifo.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_speech_write_fifo;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  speech_write_fifo_if bus_if ();

  speech_write_fifo #(
    .DEPTH       (8),
    .SYNC_STAGES (2)
  ) dut (
    .iCLK   (clk),
    .iRESET (rst),
    .bus    (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One write strobe held 3 cycles, then low 2 cycles
  task automatic strobe(input logic dk, input logic [7:0] d);
    bus_if.iCPC_DATA = d;
    if (dk) bus_if.iWRITE_DK = 1'b1;
    else    bus_if.iWRITE_SSA = 1'b1;
    tick(3);
    bus_if.iWRITE_DK  = 1'b0;
    bus_if.iWRITE_SSA = 1'b0;
    tick(2);
  endtask

  // Full four-phase handshake on the presented byte
  task automatic hs(input logic [7:0] b, input logic dk);
    chk("hs_valid", {7'd0, bus_if.oVALID}, 8'h01);
    chk("hs_byte", bus_if.oBYTE, b);
    chk("hs_tag", {7'd0, bus_if.oBYTE_DK}, {7'd0, dk});
    bus_if.iACK = 1'b1;
    tick(2);
    chk("hs_valid_before_pop", {7'd0, bus_if.oVALID}, 8'h01);
    tick(1);
    chk("hs_valid_after_pop", {7'd0, bus_if.oVALID}, 8'h00);
    bus_if.iACK = 1'b0;
    tick(4);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] lvl;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus_if.iWRITE_SSA = 1'b0;
    bus_if.iWRITE_DK  = 1'b0;
    bus_if.iCPC_DATA  = 8'h00;
    bus_if.iACK       = 1'b0;
    bus_if.iCLR_OVF   = 1'b0;
    tick(3);
    chk("rst_valid", {7'd0, bus_if.oVALID}, 8'h00);
    chk("rst_byte", bus_if.oBYTE, 8'h00);
    chk("rst_tag", {7'd0, bus_if.oBYTE_DK}, 8'h00);
    chk("rst_flags", {5'd0, bus_if.oEMPTY, bus_if.oFULL, bus_if.oOVERFLOW}, 8'h04);
    chk("rst_status", bus_if.oSTATUS, 8'h20);
    rst = 1'b0;
    tick(2);

    // Single SSA byte with exact edge timing
    bus_if.iCPC_DATA  = 8'hA5;
    bus_if.iWRITE_SSA = 1'b1;
    tick(2);
    chk("a5_status_edge2", bus_if.oSTATUS, 8'h20);
    tick(1);
    chk("a5_status_edge3", bus_if.oSTATUS, 8'h01);
    chk("a5_valid_edge3", {7'd0, bus_if.oVALID}, 8'h00);
    bus_if.iWRITE_SSA = 1'b0;
    tick(1);
    chk("a5_valid_edge4", {7'd0, bus_if.oVALID}, 8'h01);
    tick(1);
    hs(8'hA5, 1'b0);
    chk("a5_drained", bus_if.oSTATUS, 8'h20);

    // DK byte and tag
    strobe(1'b1, 8'h3C);
    hs(8'h3C, 1'b1);
    chk("3c_status", bus_if.oSTATUS, 8'h20);
    chk("3c_empty", {7'd0, bus_if.oEMPTY}, 8'h01);

    // Fill to full, then overflow with 08
    for (int i = 0; i < 8; i++) strobe(1'b0, 8'(i));
    chk("fill_status", bus_if.oSTATUS, 8'h48);
    strobe(1'b0, 8'h08);
    chk("ovf_status", bus_if.oSTATUS, 8'hC8);
    chk("ovf_flags", {6'd0, bus_if.oFULL, bus_if.oOVERFLOW}, 8'h03);
    for (int i = 0; i < 8; i++) hs(8'(i), 1'b0);
    chk("drain_status", bus_if.oSTATUS, 8'hA0);
    bus_if.iCLR_OVF = 1'b1;
    tick(1);
    bus_if.iCLR_OVF = 1'b0;
    chk("clr_status", bus_if.oSTATUS, 8'h20);

    // Push to full in the same cycle as a pop
    for (int i = 0; i < 8; i++) strobe(1'b0, 8'(8'h10 + i));
    chk("refill_status", bus_if.oSTATUS, 8'h48);
    bus_if.iCPC_DATA  = 8'h18;
    bus_if.iACK       = 1'b1;
    bus_if.iWRITE_SSA = 1'b1;
    tick(3);
    chk("simul_status", bus_if.oSTATUS, 8'h48);
    chk("simul_valid", {7'd0, bus_if.oVALID}, 8'h00);
    bus_if.iACK       = 1'b0;
    bus_if.iWRITE_SSA = 1'b0;
    tick(4);
    chk("simul_next_byte", bus_if.oBYTE, 8'h11);
    strobe(1'b0, 8'h19);
    chk("ovf2_status", bus_if.oSTATUS, 8'hC8);
    bus_if.iCLR_OVF = 1'b1;
    tick(1);
    bus_if.iCLR_OVF = 1'b0;
    chk("clr2_status", bus_if.oSTATUS, 8'h48);
    for (int i = 1; i < 6; i++) hs(8'(8'h10 + i), 1'b0);
    chk("three_left_status", bus_if.oSTATUS, 8'h03);
    chk("three_left_byte", bus_if.oBYTE, 8'h16);

    // Reset mid-handshake with ack held high across release
    rst         = 1'b1;
    bus_if.iACK = 1'b1;
    #1;
    chk("mid_rst_valid", {7'd0, bus_if.oVALID}, 8'h00);
    chk("mid_rst_byte", bus_if.oBYTE, 8'h00);
    chk("mid_rst_status", bus_if.oSTATUS, 8'h20);
    tick(2);
    rst = 1'b0;
    tick(3);
    strobe(1'b0, 8'h5A);
    chk("ack_high_status", bus_if.oSTATUS, 8'h01);
    chk("ack_high_valid", {7'd0, bus_if.oVALID}, 8'h00);
    bus_if.iACK = 1'b0;
    tick(4);
    hs(8'h5A, 1'b0);
    chk("5a_drained", bus_if.oSTATUS, 8'h20);

    // Both strobes together tag as DK
    bus_if.iCPC_DATA  = 8'h81;
    bus_if.iWRITE_SSA = 1'b1;
    bus_if.iWRITE_DK  = 1'b1;
    tick(3);
    bus_if.iWRITE_SSA = 1'b0;
    bus_if.iWRITE_DK  = 1'b0;
    tick(2);
    hs(8'h81, 1'b1);

    // One-cycle strobe: at most one push
    bus_if.iCPC_DATA  = 8'h77;
    bus_if.iWRITE_SSA = 1'b1;
    tick(1);
    bus_if.iWRITE_SSA = 1'b0;
    tick(6);
    lvl = bus_if.oSTATUS[3:0];
    chk("short_strobe_single", {7'd0, (lvl <= 4'd1)}, 8'h01);
    if (lvl == 4'd1) hs(8'h77, 1'b0);
    chk("short_drained", bus_if.oSTATUS, 8'h20);

    // Ack rising while idle and empty
    bus_if.iACK = 1'b1;
    tick(5);
    chk("idle_ack_status", bus_if.oSTATUS, 8'h20);
    chk("idle_ack_valid", {7'd0, bus_if.oVALID}, 8'h00);
    bus_if.iACK = 1'b0;
    tick(4);
    chk("idle_ack_after", bus_if.oSTATUS, 8'h20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/speech_write_fifo.md
# speech_write_fifo

Clocked receive stage between the CPC I/O write decoder and the ATmega. It synchronises the asynchronous SSA/AMDRUM and DK write strobes, and queues each latched CPC byte with a port tag in a small FIFO. It hands the bytes to the ATmega over a four-phase valid/ack handshake. A status byte is provided so a busy CPC program can check fill level and overflow without losing speech bytes.

## Interface

- DEPTH, 8, FIFO entries; power of two, 2..8
- SYNC_STAGES, 2, flip-flops in each input synchroniser; minimum 2
- iCLK  in  1  system clock (16 MHz, the ATmega clock)
- iRESET  in  1  reset; asynchronous, active-high
- iWRITE_SSA  in  1  active-high write strobe for SSA/AMDRUM, asynchronous to iCLK
- iWRITE_DK  in  1  active-high write strobe for DK'tronics, asynchronous to iCLK
- iCPC_DATA  in  8  latched CPC byte; stable from strobe rise until the next strobe
- iACK  in  1  ATmega acknowledge, asynchronous
- iCLR_OVF  in  1  synchronous pulse that clears oOVERFLOW
- oBYTE  out  8  byte presented to the ATmega
- oBYTE_DK  out  1  tag for oBYTE; 1 = DK port, 0 = SSA/AMDRUM port
- oVALID  out  1  oBYTE and oBYTE_DK are valid
- oEMPTY  out  1  FIFO empty
- oFULL  out  1  FIFO holds DEPTH entries
- oOVERFLOW  out  1  sticky; set when a byte was dropped
- oSTATUS  out  8  {oOVERFLOW, oFULL, oEMPTY, 1'b0, level[3:0]}

## Operation

- **Write synchroniser.**
  - The strobe is w = iWRITE_SSA | iWRITE_DK. It passes through SYNC_STAGES flip-flops plus one history flip-flop.
  - A push pulse is generated on a synchronised rising edge only.
  - The tag is iWRITE_DK, synchronised in the same chain.
- **Push.**
  - {tag, iCPC_DATA} is written at the write pointer on the push edge.
  - If the FIFO is full, the byte is discarded, the pointers do not change, and oOVERFLOW is set.
- **Storage.** DEPTH×9-bit register array. Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. The level counter is 0..DEPTH.
- **Handshake state machine.** iACK is synchronised the same way, giving ack_s.
  - IDLE: if the FIFO is non-empty and ack_s = 0, load oBYTE/oBYTE_DK from the head, set oVALID = 1, and go to PRESENT.
  - PRESENT: on the ack_s rising edge, pop the head, clear oVALID, and go to WAIT_LOW.
  - WAIT_LOW: when ack_s = 0, go to IDLE.
  - An ack rising edge in IDLE or WAIT_LOW is ignored; no pop occurs.
- **Simultaneous push and pop.** Both take effect and the level is unchanged. A push to a full FIFO in the same cycle as a pop is accepted.
- **oOVERFLOW.** Cleared by iCLR_OVF or reset. If set and clear occur in the same cycle, set wins.
- **Tag when both strobes fire.** This cannot happen at distinct addresses; if it does, the tag is 1.
- **Reset.**
  - Pointers, level, and synchronisers go to 0 and the state to IDLE.
  - oVALID=0, oBYTE=0, oBYTE_DK=0, oEMPTY=1, oFULL=0, oOVERFLOW=0, oSTATUS=8'h20.
  - Reset mid-handshake abandons the presented byte.
  - A high iACK after reset produces no pop, because IDLE waits for ack_s = 0.

## Timing

- Input pulses must be high for at least 2 iCLK periods. The CPC I/O write pulse satisfies this at 16 MHz.
- Inputs must stay low for at least 2 iCLK periods between pulses.
- With SYNC_STAGES=2:
  - Push occurs on the 3rd iCLK edge after the strobe rises; level, oEMPTY, oFULL and oSTATUS update on that edge.
  - If IDLE with ack_s=0, oVALID rises on the 4th edge.
- Pop occurs on the 3rd edge after iACK rises; oVALID falls on that edge and the level updates on that edge.
- After iACK falls:
  - the state reaches IDLE on the 3rd edge;
  - the next byte is presented on the 4th edge.
- oBYTE and oBYTE_DK are registered and hold steady while oVALID=1.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan

- Reset, then SSA strobe with iCPC_DATA=8'hA5 -> level 1 on edge 3, oVALID=1 on edge 4, oBYTE=8'hA5, oBYTE_DK=0, oSTATUS=8'h01.
- DK strobe with 8'h3C, then full iACK pulse -> oBYTE_DK=1; pop on edge 3 after ack rise, oVALID=0, oEMPTY=1, oSTATUS=8'h20.
- Nine strobes with 8'h00..8'h08, no ack -> oFULL=1, level 8, 8'h08 dropped, oOVERFLOW=1, oSTATUS=8'hC8. Eight handshakes then return 00..07 in order across the pointer wrap.
- Full FIFO: push lands on the same edge as the pop -> byte accepted, level stays 8, no overflow. Then iCLR_OVF pulse -> oOVERFLOW=0.
- Assert iRESET while in PRESENT with 3 queued bytes -> all outputs at reset values immediately. iACK held high through reset release produces no pop, and the next strobe's byte is delivered normally.
- Strobe of 1 iCLK period -> may be missed, but must never produce two pushes. Ack rise while IDLE -> level unchanged.
